// File: rtl/pc_branch_control.sv
// pc_branch_control
//   Program-counter and branch-redirect stage. Holds the fetch PC, advances it
//   each unstalled cycle, redirects it on a taken conditional branch or a jump,
//   and raises a registered flush pulse for FLUSH_CYCLES cycles afterwards so
//   IF/ID can squash the wrong-path instructions fetched meanwhile.
//
// Ports
//   clk            in   1         clock, all state updates on rising edge
//   reset          in   1         synchronous active-high reset
//   stall          in   1         hold the PC this cycle (redirect overrides)
//   branch_code    in   4         1..12 conditional branch, other codes = none
//   taken          in   1         evaluator result for branch_code
//   branch_target  in   PC_WIDTH  conditional branch target
//   jump           in   1         unconditional jump in decode
//   jump_target    in   PC_WIDTH  jump target
//   pc             out  PC_WIDTH  current fetch address (registered)
//   redirect       out  1         combinational: redirect accepted this cycle
//   flush          out  1         registered: squash IF/ID contents
module pc_branch_control #(
  parameter int unsigned          PC_WIDTH     = 10,
  parameter logic [PC_WIDTH-1:0]  RESET_PC     = '0,
  parameter int unsigned          FLUSH_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic [3:0]          branch_code,
  input  logic                taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic                redirect,
  output logic                flush
);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  // Counter preload: the flush pulse spans cnt values FLUSH_CYCLES-1 down to 0.
  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                flush_q, flush_d;

  logic                br_code_valid;
  logic                br_ok;
  logic                redirect_req;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] redirect_pc;

  // Codes 0 and 13..15 never branch, regardless of what the evaluator says.
  assign br_code_valid = (branch_code >= 4'd1) && (branch_code <= 4'd12);
  assign br_ok         = br_code_valid & taken;
  assign redirect_req  = jump | br_ok;
  // Jump beats branch when both are present.
  assign redirect_pc   = jump ? jump_target : branch_target;
  // Natural truncation gives the modulo-2^PC_WIDTH wrap.
  assign pc_inc        = pc_q + PC_WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pc_d     = pc_q;
    flush_d  = flush_q;
    redirect = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        flush_d = 1'b0;
        if (redirect_req) begin
          // Redirect wins over stall.
          redirect = 1'b1;
          pc_d     = redirect_pc;
          state_d  = ST_FLUSH;
          cnt_d    = CNT_LOAD;
          flush_d  = 1'b1;
        end else if (!stall) begin
          pc_d = pc_inc;
        end
      end

      ST_FLUSH: begin
        // Decode holds wrong-path instructions here: jump/branch are ignored.
        if (!stall) begin
          pc_d = pc_inc;
        end
        // The counter runs independently of stall so the pulse width is fixed.
        if (cnt_q == 4'd0) begin
          flush_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          flush_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_RUN;
        flush_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 4'd0;
      pc_q    <= RESET_PC;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  assign pc    = pc_q;
  assign flush = flush_q;

endmodule

// File: tb/tb_pc_branch_control.sv
module tb_pc_branch_control;

  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          stall;
  logic [3:0]    branch_code;
  logic          taken;
  logic [PW-1:0] branch_target;
  logic          jump;
  logic [PW-1:0] jump_target;

  logic [PW-1:0] pc2, pc1;
  logic          red2, red1;
  logic          fl2, fl1;

  always #5 clk = ~clk;

  pc_branch_control #(.PC_WIDTH(PW), .RESET_PC('0), .FLUSH_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .stall(stall), .branch_code(branch_code),
    .taken(taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .pc(pc2), .redirect(red2), .flush(fl2)
  );

  pc_branch_control #(.PC_WIDTH(PW), .RESET_PC('0), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .stall(stall), .branch_code(branch_code),
    .taken(taken), .branch_target(branch_target), .jump(jump),
    .jump_target(jump_target), .pc(pc1), .redirect(red1), .flush(fl1)
  );

  typedef struct {
    logic          rst;
    logic          stl;
    logic [3:0]    code;
    logic          tkn;
    logic [PW-1:0] bt;
    logic          jmp;
    logic [PW-1:0] jt;
    logic          exp_red;
    logic [PW-1:0] exp_pc;
    logic          exp_fl;
  } vec_t;

  typedef struct {
    int            idx;
    logic [PW-1:0] pc;
    logic          fl;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam int N2 = 31;
  localparam int N1 = 5;
  vec_t tbl2[N2];
  vec_t tbl1[N1];

  function automatic vec_t mk(input logic rst, input logic stl, input logic [3:0] code,
                              input logic tkn, input logic [PW-1:0] bt, input logic jmp,
                              input logic [PW-1:0] jt, input logic red,
                              input logic [PW-1:0] epc, input logic efl);
    vec_t v;
    v.rst = rst; v.stl = stl; v.code = code; v.tkn = tkn; v.bt = bt;
    v.jmp = jmp; v.jt = jt; v.exp_red = red; v.exp_pc = epc; v.exp_fl = efl;
    return v;
  endfunction

  // Drive one cycle of stimulus on the selected instance (sel=1 -> FLUSH_CYCLES=1).
  task automatic apply(input vec_t v, input int idx, input bit sel);
    exp_t e;
    exp_t got;
    logic          r;
    logic [PW-1:0] p;
    logic          f;
    reset = v.rst; stall = v.stl; branch_code = v.code; taken = v.tkn;
    branch_target = v.bt; jump = v.jmp; jump_target = v.jt;
    #2;
    r = sel ? red1 : red2;
    checks++;
    if (r !== v.exp_red) begin
      errors++;
      $display("FAIL redirect dut%0d row %0d: got %b want %b", sel ? 1 : 2, idx, r, v.exp_red);
    end
    e.idx = idx; e.pc = v.exp_pc; e.fl = v.exp_fl;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    p = sel ? pc1 : pc2;
    f = sel ? fl1 : fl2;
    checks++;
    if (p !== got.pc) begin
      errors++;
      $display("FAIL pc dut%0d row %0d: got %h want %h", sel ? 1 : 2, got.idx, p, got.pc);
    end
    checks++;
    if (f !== got.fl) begin
      errors++;
      $display("FAIL flush dut%0d row %0d: got %b want %b", sel ? 1 : 2, got.idx, f, got.fl);
    end
    $display("row dut%0d %0d: rst=%b stall=%b code=%0d taken=%b jump=%b red=%b pc=%h flush=%b",
             sel ? 1 : 2, idx, v.rst, v.stl, v.code, v.tkn, v.jmp, r, p, f);
  endtask

  initial begin
    // FLUSH_CYCLES = 2 instance
    //                 rst  stl  code  tkn  bt       jmp  jt      red  pc      fl
    tbl2[0]  = mk(1, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h000, 0); // reset
    tbl2[1]  = mk(0, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h001, 0);
    tbl2[2]  = mk(0, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h002, 0);
    tbl2[3]  = mk(0, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h003, 0);
    tbl2[4]  = mk(0, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h004, 0);
    tbl2[5]  = mk(0, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h005, 0);
    tbl2[6]  = mk(0, 0, 4'd1,  1, 10'h040, 0, 10'h000, 1, 10'h040, 1); // branch at pc=5
    tbl2[7]  = mk(0, 0, 4'd7,  1, 10'h300, 1, 10'h100, 0, 10'h041, 1); // ignored in FLUSH
    tbl2[8]  = mk(0, 0, 4'd0,  0, 10'h000, 1, 10'h100, 0, 10'h042, 0); // ignored in FLUSH
    tbl2[9]  = mk(0, 0, 4'd7,  1, 10'h300, 1, 10'h200, 1, 10'h200, 1); // jump beats branch
    tbl2[10] = mk(0, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h201, 1);
    tbl2[11] = mk(0, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h202, 0);
    tbl2[12] = mk(0, 0, 4'd13, 1, 10'h300, 0, 10'h000, 0, 10'h203, 0); // code 13 never branches
    tbl2[13] = mk(0, 0, 4'd0,  1, 10'h300, 0, 10'h000, 0, 10'h204, 0); // code 0 never branches
    tbl2[14] = mk(0, 0, 4'd12, 0, 10'h300, 0, 10'h000, 0, 10'h205, 0); // not taken
    tbl2[15] = mk(0, 0, 4'd12, 1, 10'h3FE, 0, 10'h000, 1, 10'h3FE, 1); // code 12 branches
    tbl2[16] = mk(0, 1, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h3FE, 1); // stall in FLUSH
    tbl2[17] = mk(0, 1, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h3FE, 0); // cnt runs under stall
    tbl2[18] = mk(0, 1, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h3FE, 0);
    tbl2[19] = mk(0, 1, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h3FE, 0);
    tbl2[20] = mk(0, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h3FF, 0);
    tbl2[21] = mk(0, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h000, 0); // wrap
    tbl2[22] = mk(0, 1, 4'd0,  0, 10'h000, 1, 10'h123, 1, 10'h123, 1); // redirect beats stall
    tbl2[23] = mk(0, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h124, 1);
    tbl2[24] = mk(0, 0, 4'd5,  1, 10'h077, 0, 10'h000, 0, 10'h125, 0); // last flush cycle
    tbl2[25] = mk(0, 0, 4'd5,  1, 10'h050, 0, 10'h000, 1, 10'h050, 1); // back-to-back
    tbl2[26] = mk(1, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h000, 0); // reset on 1st flush cycle
    tbl2[27] = mk(0, 0, 4'd3,  0, 10'h222, 0, 10'h000, 0, 10'h001, 0);
    tbl2[28] = mk(0, 0, 4'd0,  0, 10'h000, 1, 10'h3FF, 1, 10'h3FF, 1); // back in RUN
    tbl2[29] = mk(0, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h000, 1); // wrap during flush
    tbl2[30] = mk(0, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h001, 0);

    // FLUSH_CYCLES = 1 instance
    tbl1[0]  = mk(1, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h000, 0);
    tbl1[1]  = mk(0, 0, 4'd1,  1, 10'h040, 0, 10'h000, 1, 10'h040, 1);
    tbl1[2]  = mk(0, 0, 4'd0,  0, 10'h000, 1, 10'h100, 0, 10'h041, 0); // single flush cycle
    tbl1[3]  = mk(0, 0, 4'd0,  0, 10'h000, 1, 10'h010, 1, 10'h010, 1); // immediate redirect
    tbl1[4]  = mk(0, 0, 4'd0,  0, 10'h000, 0, 10'h000, 0, 10'h011, 0);

    reset = 1'b1; stall = 1'b0; branch_code = 4'd0; taken = 1'b0;
    branch_target = '0; jump = 1'b0; jump_target = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < N2; i++) apply(tbl2[i], i, 1'b0);
    for (int i = 0; i < N1; i++) apply(tbl1[i], i, 1'b1);

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
